// File: rtl/cyc_compare_seq.sv
// Sequential multi-pair RO count comparator: captures every pair on start, then
// resolves one pair per clock into a response bit and an instability flag.
module cyc_compare_seq #(
  parameter int CNT_W   = 16,
  parameter int N_PAIRS = 8,
  parameter int MARGIN  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [N_PAIRS*CNT_W-1:0]       count0,
  input  logic [N_PAIRS*CNT_W-1:0]       count1,
  output logic                           busy,
  output logic                           done,
  output logic [N_PAIRS-1:0]             resp,
  output logic [N_PAIRS-1:0]             unstable,
  output logic [$clog2(N_PAIRS+1)-1:0]   n_unstable
);

  localparam int IDX_W  = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
  localparam int CNT_NW = $clog2(N_PAIRS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_PAIRS - 1);
  localparam logic [CNT_W:0]   MARGIN_EXT = (CNT_W + 1)'(MARGIN);

  typedef enum logic {IDLE, COMPARE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    pairIdx_q, pairIdx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [N_PAIRS-1:0]  resp_q, resp_d;
  logic [N_PAIRS-1:0]  unst_q, unst_d;
  logic [CNT_NW-1:0]   nUnst_q, nUnst_d;
  logic [CNT_W-1:0]    cap0_q [N_PAIRS];
  logic [CNT_W-1:0]    cap1_q [N_PAIRS];
  logic                captureEn;

  logic [CNT_W-1:0]    curA, curB;
  logic [CNT_W:0]      absDiff;
  logic                pairGt, pairUnst;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COMPARE;
      COMPARE: if (pairIdx_q == LAST_IDX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One extra bit on the difference keeps full-scale pairs from wrapping.
  always_comb begin
    curA     = cap0_q[pairIdx_q];
    curB     = cap1_q[pairIdx_q];
    pairGt   = curA > curB;
    absDiff  = pairGt ? ({1'b0, curA} - {1'b0, curB}) : ({1'b0, curB} - {1'b0, curA});
    pairUnst = absDiff <= MARGIN_EXT;
  end

  always_comb begin
    captureEn = 1'b0;
    pairIdx_d = pairIdx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    resp_d    = resp_q;
    unst_d    = unst_q;
    nUnst_d   = nUnst_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          captureEn = 1'b1;
          pairIdx_d = '0;
          busy_d    = 1'b1;
          resp_d    = '0;
          unst_d    = '0;
          nUnst_d   = '0;
        end
      end
      COMPARE: begin
        resp_d[pairIdx_q] = pairGt;
        unst_d[pairIdx_q] = pairUnst;
        nUnst_d   = nUnst_q + CNT_NW'(pairUnst);
        pairIdx_d = pairIdx_q + IDX_W'(1);
        if (pairIdx_q == LAST_IDX) begin
          pairIdx_d = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pairIdx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      resp_q    <= '0;
      unst_q    <= '0;
      nUnst_q   <= '0;
      for (int i = 0; i < N_PAIRS; i++) begin
        cap0_q[i] <= '0;
        cap1_q[i] <= '0;
      end
    end else begin
      pairIdx_q <= pairIdx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      resp_q    <= resp_d;
      unst_q    <= unst_d;
      nUnst_q   <= nUnst_d;
      if (captureEn) begin
        for (int i = 0; i < N_PAIRS; i++) begin
          cap0_q[i] <= count0[i*CNT_W +: CNT_W];
          cap1_q[i] <= count1[i*CNT_W +: CNT_W];
        end
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign resp       = resp_q;
  assign unstable   = unst_q;
  assign n_unstable = nUnst_q;

endmodule

// File: tb/tb_cyc_compare_seq.sv
// Scoreboard bench for cyc_compare_seq: stimulus pushes model results, a monitor
// pops and compares them whenever done pulses.
module tb_cyc_compare_seq;

  localparam int CNT_W   = 16;
  localparam int N_PAIRS = 8;
  localparam int MARGIN  = 2;
  localparam int NW      = $clog2(N_PAIRS + 1);
  localparam int TIMEOUT = 200;

  typedef logic [N_PAIRS*CNT_W-1:0] bus_t;
  typedef struct {
    logic [N_PAIRS-1:0] resp;
    logic [N_PAIRS-1:0] unst;
    int                 n;
    int                 doneCycle;
  } expT;

  logic               clk    = 1'b0;
  logic               reset  = 1'b0;
  logic               start  = 1'b0;
  bus_t               count0 = '0;
  bus_t               count1 = '0;
  logic               busy, done;
  logic [N_PAIRS-1:0] resp, unstable;
  logic [NW-1:0]      n_unstable;

  int  checks  = 0;
  int  errors  = 0;
  int  edgeCnt = 0;
  expT sb[$];
  expT expd;

  cyc_compare_seq #(.CNT_W(CNT_W), .N_PAIRS(N_PAIRS), .MARGIN(MARGIN)) dut (
    .clk(clk), .reset(reset), .start(start), .count0(count0), .count1(count1),
    .busy(busy), .done(done), .resp(resp), .unstable(unstable), .n_unstable(n_unstable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h (edge %0d)", name, actual, expected, edgeCnt);
    end
  endtask

  // Reference: each pair judged independently with plain integer arithmetic.
  function automatic expT refModel(input bus_t a, input bus_t b);
    expT e;
    e.resp = '0;
    e.unst = '0;
    e.n = 0;
    e.doneCycle = 0;
    for (int i = 0; i < N_PAIRS; i++) begin
      int x, y, d;
      x = int'(a[i*CNT_W +: CNT_W]);
      y = int'(b[i*CNT_W +: CNT_W]);
      d = (x > y) ? x - y : y - x;
      e.resp[i] = (x > y);
      e.unst[i] = (d <= MARGIN);
      if (d <= MARGIN) e.n++;
    end
    return e;
  endfunction

  // Caller sits at a falling edge; start is sampled at the next rising edge.
  task automatic applyStimulus(input bus_t a, input bus_t b);
    expT e;
    count0 = a;
    count1 = b;
    start  = 1'b1;
    e = refModel(a, b);
    e.doneCycle = edgeCnt + 1 + N_PAIRS;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_timeout: pending=%0d busy=%b required pending=0 busy=0", name, sb.size(), busy);
      sb.delete();
    end
    @(negedge clk);
  endtask

  function automatic bus_t randBus();
    bus_t v;
    for (int i = 0; i < N_PAIRS; i++) v[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 65535));
    return v;
  endfunction

  // Pairs biased toward the margin boundary so unstable flags get exercised.
  task automatic randPairs(output bus_t a, output bus_t b);
    for (int i = 0; i < N_PAIRS; i++) begin
      int base, off;
      base = int'($urandom_range(0, 65535));
      case ($urandom_range(0, 2))
        0:       off = int'($urandom_range(0, 65535)) - base;
        1:       off = int'($urandom_range(0, 2*MARGIN + 2)) - (MARGIN + 1);
        default: off = 0;
      endcase
      a[i*CNT_W +: CNT_W] = CNT_W'(base);
      b[i*CNT_W +: CNT_W] = CNT_W'(base + off);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spurious_done: actual done=1 required done=0 (edge %0d)", edgeCnt);
      end else begin
        expd = sb.pop_front();
        checkOutput("done_edge", edgeCnt, expd.doneCycle);
        checkOutput("resp", 32'(resp), 32'(expd.resp));
        checkOutput("unstable", 32'(unstable), 32'(expd.unst));
        checkOutput("n_unstable", 32'(n_unstable), expd.n);
        checkOutput("busy_at_done", 32'(busy), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus_t a, b;
    int   diffs [N_PAIRS];

    start  = 1'b1;
    count0 = randBus();
    count1 = randBus();
    reset  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_resp", 32'(resp), 0);
    checkOutput("reset_unstable", 32'(unstable), 0);
    checkOutput("reset_n_unstable", 32'(n_unstable), 0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < N_PAIRS; i++) begin
      a[i*CNT_W +: CNT_W] = CNT_W'(1000 + i);
      b[i*CNT_W +: CNT_W] = CNT_W'(500);
    end
    applyStimulus(a, b);
    for (int i = 0; i < N_PAIRS; i++) begin
      checkOutput("busy_running", 32'(busy), 1);
      @(negedge clk);
    end
    checkOutput("busy_cleared", 32'(busy), 0);
    checkOutput("done_pulse", 32'(done), 1);
    @(negedge clk);
    checkOutput("done_single", 32'(done), 0);
    waitIdle("defaults");

    diffs = '{0, 1, 2, 3, -1, -2, -3, 100};
    for (int i = 0; i < N_PAIRS; i++) begin
      a[i*CNT_W +: CNT_W] = CNT_W'(1000 + diffs[i]);
      b[i*CNT_W +: CNT_W] = CNT_W'(1000);
    end
    applyStimulus(a, b);
    waitIdle("margin");

    a = randBus();
    b = a;
    a[0 +: CNT_W]     = 16'hFFFF;
    b[0 +: CNT_W]     = 16'h0000;
    a[CNT_W +: CNT_W] = 16'h0000;
    b[CNT_W +: CNT_W] = 16'hFFFF;
    applyStimulus(a, b);
    waitIdle("extremes");

    randPairs(a, b);
    applyStimulus(a, b);
    @(negedge clk);
    count0 = randBus();
    count1 = randBus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_ignores_start", 32'(busy), 1);
    repeat (5) @(negedge clk);
    checkOutput("done_before_restart", 32'(done), 1);
    randPairs(a, b);
    applyStimulus(a, b);
    waitIdle("restart_in_done");

    randPairs(a, b);
    applyStimulus(a, b);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    #1;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_done", 32'(done), 0);
    checkOutput("abort_resp", 32'(resp), 0);
    checkOutput("abort_unstable", 32'(unstable), 0);
    checkOutput("abort_n_unstable", 32'(n_unstable), 0);
    for (int i = 0; i < N_PAIRS + 2; i++) begin
      @(negedge clk);
      checkOutput("abort_no_done", 32'(done), 0);
    end
    reset = 1'b1;
    @(negedge clk);
    randPairs(a, b);
    applyStimulus(a, b);
    waitIdle("after_abort");

    for (int r = 0; r < 24; r++) begin
      randPairs(a, b);
      applyStimulus(a, b);
      waitIdle("random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
